// File: rtl/rom_msg_sequencer_if.sv
// Start request, ROM read port and character stream of rom_msg_sequencer.
// The abort line exists only when MSG_ABORT_EN is defined.
interface rom_msg_sequencer_if;
    logic       start;
    logic [7:0] start_addr;
    logic [7:0] rom_addr;
    logic [7:0] rom_data;
    logic [7:0] char_out;
    logic       char_valid;
    logic       char_ready;
    logic       busy;
    logic       done;
`ifdef MSG_ABORT_EN
    logic       abort;
`endif

    modport master (
        input  start, start_addr, rom_data, char_ready,
`ifdef MSG_ABORT_EN
        input  abort,
`endif
        output rom_addr, char_out, char_valid, busy, done
    );

    modport slave (
        output start, start_addr, rom_data, char_ready,
`ifdef MSG_ABORT_EN
        output abort,
`endif
        input  rom_addr, char_out, char_valid, busy, done
    );
endinterface

// File: rtl/rom_msg_sequencer.sv
// Streams a terminator-ended message from a 256x8 synchronous ROM, one character per handshake.
// Optional feature: define MSG_ABORT_EN to add an abort input that ends the message early.
module rom_msg_sequencer #(
    parameter int unsigned MAX_LEN   = 32,
    parameter logic [7:0]  TERM_CHAR = 8'h00
) (
    input logic                 clk,
    input logic                 rst,
    rom_msg_sequencer_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_CHECK = 3'd2,
        S_SEND  = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    // Nine bits so that a full 256-character message still terminates.
    localparam logic [8:0] MAX_LEN_C = 9'(MAX_LEN);

    state_e     state_q, state_d;
    logic [7:0] addr_q, addr_d;
    logic [8:0] count_q, count_d;
    logic [7:0] char_q, char_d;
    logic       valid_q, valid_d;
    logic       handshake_s;
    logic       abort_s;
    logic [8:0] count_inc_s;

`ifdef MSG_ABORT_EN
    assign abort_s = bus.abort;
`else
    assign abort_s = 1'b0;
`endif

    assign handshake_s = valid_q & bus.char_ready;
    assign count_inc_s = count_q + 9'd1;

    // State and datapath registers; rst returns everything to idle values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= 8'h00;
            count_q <= 9'd0;
            char_q  <= 8'h00;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            char_q  <= char_d;
            valid_q <= valid_d;
        end
    end

    // Next-state and datapath update for the fetch/check/send loop.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        count_d = count_q;
        char_d  = char_q;
        valid_d = valid_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    addr_d  = bus.start_addr;
                    count_d = 9'd0;
                    state_d = S_FETCH;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FETCH: begin
                if (abort_s) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (abort_s) begin
                    state_d = S_DONE;
                end else if (bus.rom_data == TERM_CHAR) begin
                    state_d = S_DONE;
                end else begin
                    char_d  = bus.rom_data;
                    valid_d = 1'b1;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                // An accepted character still counts when abort arrives in the same cycle.
                if (handshake_s) begin
                    count_d = count_inc_s;
                    addr_d  = addr_q + 8'd1;
                    valid_d = 1'b0;
                end else begin
                    valid_d = valid_q;
                end
                if (abort_s) begin
                    valid_d = 1'b0;
                    state_d = S_DONE;
                end else if (handshake_s) begin
                    if (count_inc_s == MAX_LEN_C) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_FETCH;
                    end
                end else begin
                    state_d = S_SEND;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    assign bus.rom_addr   = addr_q;
    assign bus.char_out   = char_q;
    assign bus.char_valid = valid_q;
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.done       = (state_q == S_DONE);
endmodule

// File: tb/tb_rom_msg_sequencer.sv
// Directed bench for rom_msg_sequencer: a default-length DUT and a MAX_LEN=4 DUT, each with its own ROM.
module tb_rom_msg_sequencer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sel = 1'b0;
    logic       start_r = 1'b0;
    logic [7:0] start_addr_r = 8'h00;
    logic       ready_r = 1'b1;
    logic       abort_r = 1'b0;

    logic [7:0] rom  [256];
    logic [7:0] rom4 [256];

    int total = 0;
    int bad   = 0;

    logic [7:0] got [16];
    int         n_got;
    int         n_done;
    logic       timed_out;
    logic       busy_after;
    logic [7:0] addr_at_done;
    logic       wrapped;

    logic [7:0] v_addr, v_char;
    logic       v_valid, v_busy, v_done;

    rom_msg_sequencer_if b  ();
    rom_msg_sequencer_if b4 ();

    always #5 clk = ~clk;

    assign b.start       = start_r & ~sel;
    assign b.start_addr  = start_addr_r;
    assign b.char_ready  = ready_r;
    assign b4.start      = start_r & sel;
    assign b4.start_addr = start_addr_r;
    assign b4.char_ready = ready_r;
`ifdef MSG_ABORT_EN
    assign b.abort  = abort_r & ~sel;
    assign b4.abort = abort_r & sel;
`endif

    always @(posedge clk) begin
        b.rom_data  <= rom[b.rom_addr];
        b4.rom_data <= rom4[b4.rom_addr];
    end

    assign v_addr  = sel ? b4.rom_addr   : b.rom_addr;
    assign v_char  = sel ? b4.char_out   : b.char_out;
    assign v_valid = sel ? b4.char_valid : b.char_valid;
    assign v_busy  = sel ? b4.busy       : b.busy;
    assign v_done  = sel ? b4.done       : b.done;

    rom_msg_sequencer #(.MAX_LEN(32), .TERM_CHAR(8'h00)) dut  (.clk(clk), .rst(rst), .bus(b));
    rom_msg_sequencer #(.MAX_LEN(4),  .TERM_CHAR(8'h00)) dut4 (.clk(clk), .rst(rst), .bus(b4));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic kick(input logic [7:0] addr);
        start_r      = 1'b1;
        start_addr_r = addr;
        step();
        start_r      = 1'b0;
    endtask

    // Samples the selected DUT each cycle until done (or the budget runs out).
    task automatic collect(input int max_cycles);
        logic [7:0] prev;
        n_got        = 0;
        n_done       = 0;
        timed_out    = 1'b1;
        busy_after   = 1'b1;
        addr_at_done = 8'h00;
        wrapped      = 1'b0;
        prev         = v_addr;
        for (int c = 0; c < max_cycles; c++) begin
            if (prev == 8'hFF && v_addr == 8'h00) wrapped = 1'b1;
            prev = v_addr;
            if (v_done) begin
                n_done++;
                addr_at_done = v_addr;
                step();
                busy_after = v_busy;
                if (v_done) n_done++;
                timed_out = 1'b0;
                break;
            end
            if (v_valid && ready_r && n_got < 16) begin
                got[n_got] = v_char;
                n_got++;
            end
            step();
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            rom[i]  = 8'h00;
            rom4[i] = 8'h60 + 8'(i);
        end
        rom[10]    = 8'h41;
        rom[11]    = 8'h42;
        rom[12]    = 8'h00;
        rom[8'hFE] = 8'h31;
        rom[8'hFF] = 8'h32;
        rom[8'h00] = 8'h33;
        rom[8'h01] = 8'h00;

        // Reset values
        rst = 1'b1;
        repeat (3) step();
        chk("rst_rom_addr", 32'(b.rom_addr), 32'h00);
        chk("rst_char_out", 32'(b.char_out), 32'h00);
        chk("rst_valid",    32'(b.char_valid), 32'h0);
        chk("rst_busy",     32'(b.busy), 32'h0);
        chk("rst_done",     32'(b.done), 32'h0);
        chk("rst4_busy",    32'(b4.busy), 32'h0);
        rst = 1'b0;
        step();

        // "AB" message with ready held high
        ready_r = 1'b1;
        kick(8'd10);
        chk("ab_busy", 32'(v_busy), 32'h1);
        collect(60);
        chk("ab_timeout",   32'(timed_out), 32'h0);
        chk("ab_count",     32'(n_got), 32'd2);
        chk("ab_char0",     32'(got[0]), 32'h41);
        chk("ab_char1",     32'(got[1]), 32'h42);
        chk("ab_done_once", 32'(n_done), 32'd1);
        chk("ab_term_addr", 32'(addr_at_done), 32'd12);
        chk("ab_idle",      32'(busy_after), 32'h0);

        // Same message with the consumer stalling for 5 cycles on "A"
        ready_r = 1'b0;
        kick(8'd10);
        step();
        step();
        for (int k = 0; k < 5; k++) begin
            chk("stall_valid", 32'(v_valid), 32'h1);
            chk("stall_char",  32'(v_char), 32'h41);
            chk("stall_addr",  32'(v_addr), 32'd10);
            step();
        end
        ready_r = 1'b1;
        collect(60);
        chk("stall_timeout", 32'(timed_out), 32'h0);
        chk("stall_count",   32'(n_got), 32'd2);
        chk("stall_char0",   32'(got[0]), 32'h41);
        chk("stall_char1",   32'(got[1]), 32'h42);

        // Address wrap FE -> FF -> 00 -> 01
        kick(8'hFE);
        collect(60);
        chk("wrap_timeout", 32'(timed_out), 32'h0);
        chk("wrap_count",   32'(n_got), 32'd3);
        chk("wrap_char0",   32'(got[0]), 32'h31);
        chk("wrap_char1",   32'(got[1]), 32'h32);
        chk("wrap_char2",   32'(got[2]), 32'h33);
        chk("wrap_seen",    32'(wrapped), 32'h1);
        chk("wrap_end",     32'(addr_at_done), 32'h01);

        // MAX_LEN=4 instance, no terminator; a start while busy must be ignored
        sel = 1'b1;
        step();
        kick(8'h00);
        start_r      = 1'b1;
        start_addr_r = 8'h05;
        step();
        start_r      = 1'b0;
        chk("max_addr_hold", 32'(v_addr), 32'h00);
        collect(60);
        chk("max_timeout",   32'(timed_out), 32'h0);
        chk("max_count",     32'(n_got), 32'd4);
        chk("max_char0",     32'(got[0]), 32'h60);
        chk("max_char3",     32'(got[3]), 32'h63);
        chk("max_done_once", 32'(n_done), 32'd1);
        chk("max_idle",      32'(busy_after), 32'h0);
        sel = 1'b0;
        step();

        // Reset in the middle of SEND, then a fresh message
        ready_r = 1'b0;
        kick(8'd10);
        step();
        step();
        chk("mid_in_send", 32'(b.char_valid), 32'h1);
        rst = 1'b1;
        step();
        chk("mid_valid", 32'(b.char_valid), 32'h0);
        chk("mid_done",  32'(b.done), 32'h0);
        chk("mid_addr",  32'(b.rom_addr), 32'h00);
        chk("mid_busy",  32'(b.busy), 32'h0);
        rst = 1'b0;
        ready_r = 1'b1;
        step();
        kick(8'd10);
        collect(60);
        chk("post_timeout", 32'(timed_out), 32'h0);
        chk("post_count",   32'(n_got), 32'd2);
        chk("post_char1",   32'(got[1]), 32'h42);

`ifdef MSG_ABORT_EN
        // Abort while checking the second character
        kick(8'd10);
        step();
        step();
        chk("abort_first", 32'(b.char_out), 32'h41);
        step();
        step();
        chk("abort_at_check", 32'(b.rom_addr), 32'd11);
        chk("abort_valid_pre", 32'(b.char_valid), 32'h0);
        abort_r = 1'b1;
        step();
        abort_r = 1'b0;
        chk("abort_done",  32'(b.done), 32'h1);
        chk("abort_valid", 32'(b.char_valid), 32'h0);
        step();
        chk("abort_idle",  32'(b.busy), 32'h0);
        chk("abort_nodone", 32'(b.done), 32'h0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
